iic_cmd_arbiter: RTL and testbench

- Shares one iic_master between N_REQ independent requesters, such as the sensor-config FSM, the ADC-readout engine and the host register bridge.
- Selects one pending single-register transaction by round-robin and latches its fields.
- Drives start to iic_master and waits for done, with a watchdog timeout.
- Returns rdata and status to the granted requester, then re-arbitrates.

---
 rtl/iic_cmd_arbiter.sv | 179 +++++++++++++++++
 tb/tb_iic_cmd_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_cmd_arbiter.sv
// iic_cmd_arbiter
// Shares one iic_master between N_REQ requesters. A pending single-register
// transaction is picked round-robin, its fields are latched and handed to the
// master, and the result (or a watchdog abort) is returned to the requester
// that was granted.

module iic_cmd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    input  logic [7*N_REQ-1:0]       req_dev_addr,
    input  logic [8*N_REQ-1:0]       req_reg_addr,
    input  logic [N_REQ-1:0]         req_wr,
    input  logic [8*N_REQ-1:0]       req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [7:0]               rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     m_en,
    output logic                     m_start,
    output logic [6:0]               m_dev_addr,
    output logic [7:0]               m_reg_addr,
    output logic                     m_wr,
    output logic [7:0]               m_wdata,
    input  logic [7:0]               m_rdata,
    input  logic                     m_done
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_INIT = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state, state_n;
    logic [IW-1:0]     ptr, ptr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [N_REQ-1:0]  gnt_n;
    logic              rsp_valid_n;
    logic [IW-1:0]     rsp_id_n;
    logic [7:0]        rsp_rdata_n;
    logic              rsp_err_n;
    logic              m_start_n;
    logic [6:0]        m_dev_addr_n;
    logic [7:0]        m_reg_addr_n;
    logic              m_wr_n;
    logic [7:0]        m_wdata_n;

    logic              sel_found;
    logic [IW-1:0]     sel_idx;

    // Round-robin search: first requester after the last granted one
    always_comb begin
        int cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    // Next-state and next-output logic for the transaction sequencer
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        cnt_n        = cnt;
        gnt_n        = '0;
        rsp_valid_n  = 1'b0;
        rsp_id_n     = rsp_id;
        rsp_rdata_n  = rsp_rdata;
        rsp_err_n    = rsp_err;
        m_start_n    = m_start;
        m_dev_addr_n = m_dev_addr;
        m_reg_addr_n = m_reg_addr;
        m_wr_n       = m_wr;
        m_wdata_n    = m_wdata;

        case (state)
            S_IDLE: begin
                if (en && sel_found) begin
                    state_n        = S_ISSUE;
                    ptr_n          = sel_idx;
                    gnt_n[sel_idx] = 1'b1;
                    m_dev_addr_n   = req_dev_addr[int'(sel_idx)*7 +: 7];
                    m_reg_addr_n   = req_reg_addr[int'(sel_idx)*8 +: 8];
                    m_wr_n         = req_wr[sel_idx];
                    m_wdata_n      = req_wdata[int'(sel_idx)*8 +: 8];
                end
            end
            S_ISSUE: begin
                m_start_n = 1'b1;
                cnt_n     = '0;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                cnt_n = cnt + 1'b1;
                if (m_done) begin
                    rsp_rdata_n = m_wr ? 8'h00 : m_rdata;
                    rsp_err_n   = 1'b0;
                    rsp_id_n    = ptr;
                    rsp_valid_n = 1'b1;
                    m_start_n   = 1'b0;
                    state_n     = S_RESP;
                end else if (cnt == CNT_LAST) begin
                    rsp_rdata_n = 8'h00;
                    rsp_err_n   = 1'b1;
                    rsp_id_n    = ptr;
                    rsp_valid_n = 1'b1;
                    m_start_n   = 1'b0;
                    state_n     = S_RESP;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= PTR_INIT;
            cnt        <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rdata  <= 8'h00;
            rsp_err    <= 1'b0;
            m_en       <= 1'b0;
            m_start    <= 1'b0;
            m_dev_addr <= 7'h00;
            m_reg_addr <= 8'h00;
            m_wr       <= 1'b0;
            m_wdata    <= 8'h00;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            gnt        <= gnt_n;
            rsp_valid  <= rsp_valid_n;
            rsp_id     <= rsp_id_n;
            rsp_rdata  <= rsp_rdata_n;
            rsp_err    <= rsp_err_n;
            m_en       <= en;
            m_start    <= m_start_n;
            m_dev_addr <= m_dev_addr_n;
            m_reg_addr <= m_reg_addr_n;
            m_wr       <= m_wr_n;
            m_wdata    <= m_wdata_n;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_iic_cmd_arbiter.sv
// Testbench for iic_cmd_arbiter: transaction-level reference model of the
// requesters, the arbiter and an iic_master stand-in, with a response
// scoreboard drained by an independent monitor.

module tb_iic_cmd_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic [N-1:0]     req = '0;
    logic [7*N-1:0]   req_dev_addr = '0;
    logic [8*N-1:0]   req_reg_addr = '0;
    logic [N-1:0]     req_wr = '0;
    logic [8*N-1:0]   req_wdata = '0;
    logic [N-1:0]     gnt;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [7:0]       rsp_rdata;
    logic             rsp_err;
    logic             busy;
    logic             m_en;
    logic             m_start;
    logic [6:0]       m_dev_addr;
    logic [7:0]       m_reg_addr;
    logic             m_wr;
    logic [7:0]       m_wdata;
    logic [7:0]       m_rdata = 8'h00;
    logic             m_done = 1'b0;

    iic_cmd_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
        .req_wr(req_wr), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .m_en(m_en), .m_start(m_start), .m_dev_addr(m_dev_addr),
        .m_reg_addr(m_reg_addr), .m_wr(m_wr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] dev;
        logic [7:0] rg;
        logic       wr;
        logic [7:0] wd;
    } txn_t;

    typedef struct {
        int         id;
        logic [7:0] rdata;
        logic       err;
        int         at;
    } rsp_t;

    txn_t pend [N];
    bit   pend_v [N];
    rsp_t expq [$];

    int checks = 0;
    int passes = 0;

    // Model state: arbiter pointer, busy window and current transaction
    int         m_ptr = N - 1;
    bit         idle_now = 1'b1;
    int         wait0 = -1;
    int         rsp_cyc = -1;
    txn_t       cur;
    int         cur_id = 0;
    int         dly = -1;
    logic [7:0] dly_data = 8'h00;

    bit           rst_prev = 1'b1;
    bit           en_prev = 1'b0;
    logic [N-1:0] req_prev = '0;

    // Knobs for directed phases: -1 random, -2 master never answers
    bit en_cur = 1'b1;
    int refill_pct = 0;
    int force_delay = -1;
    int force_rdata = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic int rrPick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic txn_t randTxn();
        txn_t t;
        t.dev = 7'($urandom);
        t.rg  = 8'($urandom);
        t.wr  = 1'($urandom);
        t.wd  = 8'($urandom);
        return t;
    endfunction

    // One clock cycle: predict and check this cycle, then drive the next inputs
    task automatic applyStimulus(input bit do_rst);
        logic [N-1:0] exp_gnt;
        bit           idle_last;
        bit           in_wait;
        int           g;
        int           r;
        rsp_t         e;
        @(negedge clk);
        exp_gnt   = '0;
        idle_last = idle_now;
        if (rst_prev) begin
            idle_now = 1'b1;
            m_ptr    = N - 1;
            wait0    = -1;
            rsp_cyc  = -1;
            expq.delete();
            checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
            checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
            checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
            checkOutput("rst_m_dev_addr", 32'(m_dev_addr), 32'd0);
            checkOutput("rst_m_reg_addr", 32'(m_reg_addr), 32'd0);
            checkOutput("rst_m_wr", 32'(m_wr), 32'd0);
            checkOutput("rst_m_wdata", 32'(m_wdata), 32'd0);
        end else if (idle_last && en_prev && (req_prev != '0)) begin
            g          = rrPick(m_ptr, req_prev);
            exp_gnt[g] = 1'b1;
            m_ptr      = g;
            cur        = pend[g];
            cur_id     = g;
            pend_v[g]  = 1'b0;
            idle_now   = 1'b0;
            wait0      = cyc + 1;
            rsp_cyc    = -1;
        end else if (!idle_now && rsp_cyc >= 0 && cyc == rsp_cyc + 1) begin
            idle_now = 1'b1;
        end

        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("busy", 32'(busy), 32'(!idle_now));
        in_wait = !idle_now && wait0 >= 0 && cyc >= wait0 && (rsp_cyc < 0 || cyc < rsp_cyc);
        checkOutput("m_start", 32'(m_start), 32'(in_wait));
        checkOutput("m_en", 32'(m_en), rst_prev ? 32'd0 : 32'(en_prev));

        if (!idle_now && cyc == wait0) begin
            checkOutput("m_dev_addr", 32'(m_dev_addr), 32'(cur.dev));
            checkOutput("m_reg_addr", 32'(m_reg_addr), 32'(cur.rg));
            checkOutput("m_wr", 32'(m_wr), 32'(cur.wr));
            checkOutput("m_wdata", 32'(m_wdata), 32'(cur.wd));
            if (force_delay != -1) dly = (force_delay == -2) ? -1 : force_delay;
            else begin
                r = $urandom_range(0, 19);
                if (r < 14) dly = $urandom_range(0, TO - 2);
                else if (r < 17) dly = TO - 1;
                else dly = -1;
            end
            dly_data = (force_rdata >= 0) ? 8'(force_rdata) : 8'($urandom);
            e.id = cur_id;
            if (dly >= 0 && dly < TO) begin
                e.at    = wait0 + dly + 1;
                e.err   = 1'b0;
                e.rdata = cur.wr ? 8'h00 : dly_data;
            end else begin
                e.at    = wait0 + TO;
                e.err   = 1'b1;
                e.rdata = 8'h00;
            end
            rsp_cyc = e.at;
            expq.push_back(e);
            in_wait = 1'b1;
        end

        if (in_wait && dly >= 0 && cyc - wait0 == dly) begin
            m_done  = 1'b1;
            m_rdata = dly_data;
        end else begin
            m_done  = !in_wait && ($urandom_range(0, 9) == 0);
            m_rdata = 8'($urandom);
        end

        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && $urandom_range(1, 100) <= refill_pct) begin
                pend[i]   = randTxn();
                pend_v[i] = 1'b1;
            end
            req[i] = pend_v[i];
            if (pend_v[i]) begin
                req_dev_addr[i*7 +: 7] = pend[i].dev;
                req_reg_addr[i*8 +: 8] = pend[i].rg;
                req_wr[i]              = pend[i].wr;
                req_wdata[i*8 +: 8]    = pend[i].wd;
            end else begin
                req_dev_addr[i*7 +: 7] = 7'($urandom);
                req_reg_addr[i*8 +: 8] = 8'($urandom);
                req_wr[i]              = 1'($urandom);
                req_wdata[i*8 +: 8]    = 8'($urandom);
            end
        end
        rst      = do_rst;
        en       = en_cur;
        rst_prev = do_rst;
        en_prev  = en_cur;
        req_prev = req;
    endtask

    function automatic bit anyPending();
        for (int i = 0; i < N; i++) if (pend_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Run until every pending request has been served and answered
    task automatic runUntilIdle(input int max_cycles);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0);
            n++;
        end while (!(idle_now && !anyPending() && expq.size() == 0) && n < max_cycles);
        if (!(idle_now && !anyPending() && expq.size() == 0))
            checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                    checkOutput("rsp_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    // Directed phases followed by a randomized soak
    initial begin
        int n;
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b0);

        $display("[TB] single write");
        pend[0] = '{7'h51, 8'h02, 1'b1, 8'h0F};
        pend_v[0] = 1'b1;
        force_delay = 10;
        runUntilIdle(100);

        $display("[TB] single read");
        pend[2] = '{7'h2A, 8'h10, 1'b0, 8'h77};
        pend_v[2] = 1'b1;
        force_delay = 5;
        force_rdata = 8'hA5;
        runUntilIdle(100);
        force_rdata = -1;

        $display("[TB] round robin");
        applyStimulus(1'b1);
        refill_pct = 100;
        force_delay = 3;
        for (int i = 0; i < 40; i++) applyStimulus(1'b0);
        refill_pct = 0;
        runUntilIdle(200);

        $display("[TB] timeout");
        pend[1] = randTxn();
        pend_v[1] = 1'b1;
        force_delay = -2;
        runUntilIdle(100);
        pend[3] = randTxn();
        pend_v[3] = 1'b1;
        force_delay = 4;
        runUntilIdle(100);

        $display("[TB] done on last counter value");
        pend[0] = '{7'h11, 8'h22, 1'b0, 8'h33};
        pend_v[0] = 1'b1;
        force_delay = TO - 1;
        force_rdata = 8'h3C;
        runUntilIdle(100);
        force_rdata = -1;

        $display("[TB] reset during wait");
        pend[1] = randTxn();
        pend_v[1] = 1'b1;
        force_delay = -2;
        n = 0;
        do begin
            applyStimulus(1'b0);
            n++;
        end while (!(!idle_now && wait0 >= 0 && cyc >= wait0 + 3) && n < 50);
        if (n >= 50) checkOutput("reach_wait_timeout", 32'd0, 32'd1);
        pend[0] = randTxn();
        pend_v[0] = 1'b1;
        pend[2] = randTxn();
        pend_v[2] = 1'b1;
        applyStimulus(1'b1);
        force_delay = 2;
        runUntilIdle(100);

        $display("[TB] random soak");
        force_delay = -1;
        refill_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            en_cur = ($urandom_range(0, 9) != 0);
            applyStimulus($urandom_range(0, 599) == 0);
        end
        en_cur = 1'b1;
        refill_pct = 0;
        runUntilIdle(400);

        checkOutput("rsp_pending", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
